token_run_meter: RTL and testbench

Sits after the token-doubling stage and consumes its serial token stream, one bit per clock. Measures the length of every maximal run of consecutive `1` tokens. Queues each completed run length in a small FIFO and presents it on a valid/ready output port. Lets downstream logic and testbenches check doubled-token run lengths without bit-level monitoring.

---
 rtl/token_run_meter_if.sv | 38 +++
 rtl/token_run_meter.sv | 176 +++++++++++++++++
 tb/tb_token_run_meter.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/token_run_meter_if.sv
// Output port bundle for token_run_meter: completed run lengths on a
// valid/ready handshake, plus FIFO occupancy and the sticky drop flag.
// Optional macro TOKEN_RUN_METER_SAT_EN adds the run_sat signal.
interface token_run_meter_if #(
  parameter int W     = 8,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          run_valid;
  logic          run_ready;
  logic [W-1:0]  run_len;
  logic [CW-1:0] count;
  logic          drop;
`ifdef TOKEN_RUN_METER_SAT_EN
  logic          run_sat;

  modport master (
    output run_valid, run_len, count, drop, run_sat,
    input  run_ready
  );

  modport slave (
    input  run_valid, run_len, count, drop, run_sat,
    output run_ready
  );
`else
  modport master (
    output run_valid, run_len, count, drop,
    input  run_ready
  );

  modport slave (
    input  run_valid, run_len, count, drop,
    output run_ready
  );
`endif
endinterface

// File: rtl/token_run_meter.sv
// token_run_meter: measures every maximal run of 1 tokens on a serial stream,
// queues completed run lengths in a small FIFO and presents them on a
// valid/ready port. A run is only reported once a 0 terminates it.
// Optional macro TOKEN_RUN_METER_SAT_EN: each entry carries a flag marking
// runs that continued past the saturated counter value.
module token_run_meter #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a,
  token_run_meter_if.master out_if
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
`ifdef TOKEN_RUN_METER_SAT_EN
  localparam int EW = W + 1;
`else
  localparam int EW = W;
`endif

  localparam logic [W-1:0]  CNT_MAX  = {W{1'b1}};
  localparam logic [W-1:0]  CNT_ZERO = {W{1'b0}};
  localparam logic [W-1:0]  CNT_ONE  = W'(1);
  localparam logic [CW-1:0] OCC_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] OCC_ONE  = CW'(1);
  localparam logic [CW-1:0] OCC_FULL = CW'(DEPTH);
  localparam logic [PW-1:0] PTR_ZERO = {PW{1'b0}};
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [EW-1:0] ENT_ZERO = {EW{1'b0}};

  // Run counter and FIFO state
  logic [W-1:0]  cnt_q, cnt_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          drop_q, drop_d;
  logic [EW-1:0] mem_q [DEPTH];
`ifdef TOKEN_RUN_METER_SAT_EN
  logic          sat_q, sat_d;
`endif

  // Per-cycle events
  logic          push_s;
  logic          pop_s;
  logic          full_s;
  logic          push_ok_s;
  logic [EW-1:0] entry_s;

  // Decode push/pop events; a push into a full FIFO is accepted only when
  // the head leaves on the same edge, which frees the slot being written.
  always_comb begin
    push_s    = 1'b0;
    pop_s     = 1'b0;
    full_s    = 1'b0;
    push_ok_s = 1'b0;
    push_s    = (a == 1'b0) && (cnt_q != CNT_ZERO);
    pop_s     = (count_q != OCC_ZERO) && out_if.run_ready;
    full_s    = (count_q == OCC_FULL);
    push_ok_s = push_s && (!full_s || pop_s);
  end

  // Assemble the FIFO entry for a completed run.
  always_comb begin
    entry_s = ENT_ZERO;
`ifdef TOKEN_RUN_METER_SAT_EN
    entry_s = {sat_q, cnt_q};
`else
    entry_s = cnt_q;
`endif
  end

  // Next-state for the run counter (saturating) and the overflow flag.
  always_comb begin
    cnt_d = cnt_q;
    if (a) begin
      if (cnt_q == CNT_MAX) begin
        cnt_d = cnt_q;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end else begin
      cnt_d = CNT_ZERO;
    end
  end

`ifdef TOKEN_RUN_METER_SAT_EN
  // Overflow flag: set by a 1 arriving while the counter is already at max.
  always_comb begin
    sat_d = sat_q;
    if (a) begin
      sat_d = sat_q | (cnt_q == CNT_MAX);
    end else begin
      sat_d = 1'b0;
    end
  end
`endif

  // Next-state for pointers, occupancy and the sticky drop flag.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    drop_d   = drop_q;
    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_s})
      2'b10:   count_d = count_q + OCC_ONE;
      2'b01:   count_d = count_q - OCC_ONE;
      default: count_d = count_q;
    endcase
    if (push_s && !push_ok_s) begin
      drop_d = 1'b1;
    end else begin
      drop_d = drop_q;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= CNT_ZERO;
      wr_ptr_q <= PTR_ZERO;
      rd_ptr_q <= PTR_ZERO;
      count_q  <= OCC_ZERO;
      drop_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      drop_q   <= drop_d;
    end
  end

`ifdef TOKEN_RUN_METER_SAT_EN
  // Overflow flag register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_q <= 1'b0;
    end else begin
      sat_q <= sat_d;
    end
  end
`endif

  // FIFO storage; cleared on reset so the head reads 0 while empty after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= ENT_ZERO;
      end
    end else if (push_ok_s) begin
      mem_q[wr_ptr_q] <= entry_s;
    end
  end

  // Outputs come straight from registered state; run_ready never reaches them.
  assign out_if.run_valid = (count_q != OCC_ZERO);
  assign out_if.run_len   = mem_q[rd_ptr_q][W-1:0];
  assign out_if.count     = count_q;
  assign out_if.drop      = drop_q;
`ifdef TOKEN_RUN_METER_SAT_EN
  assign out_if.run_sat   = mem_q[rd_ptr_q][W];
`endif

endmodule

// File: tb/tb_token_run_meter.sv
// Self-checking bench for token_run_meter (W=8, DEPTH=4): a vector table for
// the single-run and back-to-back cases, plus hand-written sequences for
// backpressure/drop, full-with-pop, saturation and asynchronous reset.
module tb_token_run_meter;
  localparam int W     = 8;
  localparam int DEPTH = 4;

  logic clk;
  logic rst;
  logic a;

  int checks;
  int errors;

  token_run_meter_if #(.W(W), .DEPTH(DEPTH)) out_if ();

  token_run_meter #(.W(W), .DEPTH(DEPTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .a      (a),
    .out_if (out_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       a;
    logic       rdy;
    logic       e_valid;
    logic [7:0] e_len;
    logic [2:0] e_count;
    logic       e_drop;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic av, input logic rv);
    @(negedge clk);
    a = av;
    out_if.run_ready = rv;
  endtask

  task automatic run_of(input int n, input logic rv);
    for (int i = 0; i < n; i++) drive(1'b1, rv);
    drive(1'b0, rv);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    a = 1'b0;
    out_if.run_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_vec(input int i, input logic av, input logic rv, input logic ev,
                         input logic [7:0] el, input logic [2:0] ec, input logic ed);
    vecs[i].a = av;
    vecs[i].rdy = rv;
    vecs[i].e_valid = ev;
    vecs[i].e_len = el;
    vecs[i].e_count = ec;
    vecs[i].e_drop = ed;
  endtask

  initial begin
    checks = 0;
    errors = 0;

    // single run 0,1,1,1,0,0 then idle; outputs shown are those before each edge
    set_vec(0,  1'b0, 1'b1, 1'b0, 8'd0, 3'd0, 1'b0);
    set_vec(1,  1'b1, 1'b1, 1'b0, 8'd0, 3'd0, 1'b0);
    set_vec(2,  1'b1, 1'b1, 1'b0, 8'd0, 3'd0, 1'b0);
    set_vec(3,  1'b1, 1'b1, 1'b0, 8'd0, 3'd0, 1'b0);
    set_vec(4,  1'b0, 1'b1, 1'b0, 8'd0, 3'd0, 1'b0);
    set_vec(5,  1'b0, 1'b1, 1'b1, 8'd3, 3'd1, 1'b0);
    set_vec(6,  1'b0, 1'b1, 1'b0, 8'd0, 3'd0, 1'b0);
    // back-to-back runs 1,0,1,1,0,1,0
    set_vec(7,  1'b1, 1'b1, 1'b0, 8'd0, 3'd0, 1'b0);
    set_vec(8,  1'b0, 1'b1, 1'b0, 8'd0, 3'd0, 1'b0);
    set_vec(9,  1'b1, 1'b1, 1'b1, 8'd1, 3'd1, 1'b0);
    set_vec(10, 1'b1, 1'b1, 1'b0, 8'd0, 3'd0, 1'b0);
    set_vec(11, 1'b0, 1'b1, 1'b0, 8'd0, 3'd0, 1'b0);
    set_vec(12, 1'b1, 1'b1, 1'b1, 8'd2, 3'd1, 1'b0);
    set_vec(13, 1'b0, 1'b1, 1'b0, 8'd0, 3'd0, 1'b0);
    set_vec(14, 1'b0, 1'b1, 1'b1, 8'd1, 3'd1, 1'b0);
    set_vec(15, 1'b0, 1'b1, 1'b0, 8'd0, 3'd0, 1'b0);

    // reset state
    rst = 1'b1;
    a = 1'b0;
    out_if.run_ready = 1'b0;
    #1;
    chk("rst_valid", 32'(out_if.run_valid), 32'd0);
    chk("rst_len",   32'(out_if.run_len),   32'd0);
    chk("rst_count", 32'(out_if.count),     32'd0);
    chk("rst_drop",  32'(out_if.drop),      32'd0);
`ifdef TOKEN_RUN_METER_SAT_EN
    chk("rst_sat",   32'(out_if.run_sat),   32'd0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // table: single run and back-to-back runs
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].a, vecs[i].rdy);
      chk($sformatf("vec%0d_valid", i), 32'(out_if.run_valid), 32'(vecs[i].e_valid));
      chk($sformatf("vec%0d_count", i), 32'(out_if.count),     32'(vecs[i].e_count));
      chk($sformatf("vec%0d_drop", i),  32'(out_if.drop),      32'(vecs[i].e_drop));
      if (vecs[i].e_valid) begin
        chk($sformatf("vec%0d_len", i), 32'(out_if.run_len), 32'(vecs[i].e_len));
      end
    end

    // backpressure and drop: runs 1..5, consumer stalled
    do_reset();
    for (int k = 1; k <= 5; k++) run_of(k, 1'b0);
    drive(1'b0, 1'b1);
    chk("bp_count_full", 32'(out_if.count), 32'd4);
    chk("bp_drop_set",   32'(out_if.drop),  32'd1);
    chk("bp_valid",      32'(out_if.run_valid), 32'd1);
    chk("bp_len1",       32'(out_if.run_len), 32'd1);
    for (int k = 2; k <= 4; k++) begin
      drive(1'b0, 1'b1);
      chk($sformatf("bp_len%0d", k), 32'(out_if.run_len), 32'(k));
      chk($sformatf("bp_valid%0d", k), 32'(out_if.run_valid), 32'd1);
    end
    drive(1'b0, 1'b0);
    chk("bp_empty_valid", 32'(out_if.run_valid), 32'd0);
    chk("bp_empty_count", 32'(out_if.count),     32'd0);
    chk("bp_drop_sticky", 32'(out_if.drop),      32'd1);

    // full FIFO with a run ending on the same edge as a pop
    do_reset();
    for (int k = 0; k < 4; k++) run_of(1, 1'b0);
    for (int k = 0; k < 3; k++) drive(1'b1, 1'b0);
    drive(1'b0, 1'b1);
    chk("fp_pre_count", 32'(out_if.count), 32'd4);
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b1);
      chk($sformatf("fp_count%0d", k), 32'(out_if.count), 32'(4 - k));
      chk($sformatf("fp_len%0d", k), 32'(out_if.run_len), (k == 3) ? 32'd3 : 32'd1);
      chk($sformatf("fp_drop%0d", k), 32'(out_if.drop), 32'd0);
    end
    drive(1'b0, 1'b0);
    chk("fp_empty_valid", 32'(out_if.run_valid), 32'd0);

    // saturation: 300 ones, then exactly 255 ones
    do_reset();
    for (int k = 0; k < 300; k++) drive(1'b1, 1'b1);
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b1);
    chk("sat300_valid", 32'(out_if.run_valid), 32'd1);
    chk("sat300_len",   32'(out_if.run_len),   32'd255);
`ifdef TOKEN_RUN_METER_SAT_EN
    chk("sat300_flag",  32'(out_if.run_sat),   32'd1);
`endif
    for (int k = 0; k < 255; k++) drive(1'b1, 1'b1);
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b1);
    chk("sat255_valid", 32'(out_if.run_valid), 32'd1);
    chk("sat255_len",   32'(out_if.run_len),   32'd255);
`ifdef TOKEN_RUN_METER_SAT_EN
    chk("sat255_flag",  32'(out_if.run_sat),   32'd0);
`endif

    // asynchronous reset with 2 queued entries and a run of 5 in progress
    do_reset();
    run_of(1, 1'b0);
    run_of(1, 1'b0);
    for (int k = 0; k < 5; k++) drive(1'b1, 1'b0);
    @(posedge clk);
    #1;
    chk("ar_pre_count", 32'(out_if.count), 32'd2);
    #1;
    rst = 1'b1;
    #1;
    chk("ar_valid", 32'(out_if.run_valid), 32'd0);
    chk("ar_count", 32'(out_if.count),     32'd0);
    chk("ar_drop",  32'(out_if.drop),      32'd0);
    @(negedge clk);
    rst = 1'b0;
    a = 1'b1;
    out_if.run_ready = 1'b1;
    drive(1'b1, 1'b1);
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b1);
    chk("ar_post_valid", 32'(out_if.run_valid), 32'd1);
    chk("ar_post_len",   32'(out_if.run_len),   32'd2);
    chk("ar_post_count", 32'(out_if.count),     32'd1);
    drive(1'b0, 1'b1);
    chk("ar_post_empty", 32'(out_if.run_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
